dcs_sparse_attn: RTL and testbench

// - Parametrised sparse-attention core. Streams in an N x D token matrix X, builds the Gram matrix H = X*X^T,

---
 rtl/dcs_sparse_attn_if.sv | 34 +++
 rtl/dcs_sparse_attn.sv | 238 +++++++++++++++++++++++
 tb/tb_dcs_sparse_attn.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcs_sparse_attn_if.sv
// -----------------------------------------------------------------------------
// dcs_sparse_attn_if
// Stream bundle for the sparse-attention core: three valid/ready channels.
//   i_valid/i_ready/i_data : token matrix X, row-major, DW bits per element
//   w_valid/w_ready/w_data : weight vector w, DW bits per element
//   o_valid/o_ready/o_data : result vector out, OW bits per word
// Modports:
//   master : the side that feeds X and w and consumes out (testbench / host)
//   slave  : the core itself
// -----------------------------------------------------------------------------
interface dcs_sparse_attn_if #(
  parameter int DW = 8,
  parameter int OW = 32
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          o_valid;
  logic          o_ready;
  logic [OW-1:0] o_data;

  modport master (
    output i_valid, i_data, w_valid, w_data, o_ready,
    input  i_ready, w_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, w_valid, w_data, o_ready,
    output i_ready, w_ready, o_valid, o_data
  );
endinterface

// File: rtl/dcs_sparse_attn.sv
// -----------------------------------------------------------------------------
// dcs_sparse_attn
// Sparse-attention core. Loads an N x D token matrix X, forms the Gram matrix
// H = X*X^T with N parallel multipliers (one X column element per cycle), takes
// the floor row mean of H, then streams in an N-entry weight vector w and
// accumulates out[i] = sum_j (H[i][j] >= avg[i] ? H[i][j] : 0) * w[j].
// The N results are emitted in order on the output stream.
//
// Phases: LOAD_X (N*D beats) -> GRAM (N*D cycles) -> AVG (1 cycle)
//         -> LOAD_W (N beats) -> OUT (N beats) -> LOAD_X
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, aborts any frame in progress
//   bus   : dcs_sparse_attn_if.slave (X input, w input, result output)
//
// Configuration:
//   DCSF_SIGNED_EN : when defined, X and w are two's complement and all of
//                    H, avg, the keep compare and out are signed; o_data is
//                    sign-extended. When undefined everything is unsigned and
//                    o_data is zero-extended.
//
// Parameters: N (power of two, >= 2), D, DW, OW (>= 2*DW+clog2(D)+DW+clog2(N)).
// -----------------------------------------------------------------------------
module dcs_sparse_attn #(
  parameter int N  = 8,
  parameter int D  = 16,
  parameter int DW = 8,
  parameter int OW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcs_sparse_attn_if.slave      bus
);

  localparam int HW  = 2 * DW + $clog2(D);   // one Gram entry, exact
  localparam int LGN = $clog2(N);
  localparam int SW  = HW + LGN;             // row sum of H, exact
  localparam int AW  = HW + DW + LGN;        // out accumulator, exact
  localparam int RW  = LGN;
  localparam int CW  = (D > 1) ? $clog2(D) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(D - 1);

  localparam logic [2:0] S_LOAD_X = 3'd0;
  localparam logic [2:0] S_GRAM   = 3'd1;
  localparam logic [2:0] S_AVG    = 3'd2;
  localparam logic [2:0] S_LOAD_W = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

`ifdef DCSF_SIGNED_EN
  typedef logic signed [DW-1:0]   e_t;
  typedef logic signed [2*DW-1:0] p_t;
  typedef logic signed [HW-1:0]   h_t;
  typedef logic signed [SW-1:0]   s_t;
  typedef logic signed [AW-1:0]   a_t;
`else
  typedef logic        [DW-1:0]   e_t;
  typedef logic        [2*DW-1:0] p_t;
  typedef logic        [HW-1:0]   h_t;
  typedef logic        [SW-1:0]   s_t;
  typedef logic        [AW-1:0]   a_t;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]    state_q,   state_d;
  logic [RW-1:0] row_q,     row_d;      // X row / Gram row / w index / out index
  logic [CW-1:0] col_q,     col_d;      // X column / Gram feature index
  logic          i_ready_q, i_ready_d;
  logic          w_ready_q, w_ready_d;
  logic          o_valid_q, o_valid_d;

  e_t x_q   [N][D];
  e_t x_d   [N][D];
  h_t h_q   [N][N];
  h_t h_d   [N][N];
  h_t avg_q [N];
  h_t avg_d [N];
  a_t out_q [N];
  a_t out_d [N];

  s_t            row_sum [N];
  logic          i_fire, w_fire, o_fire;
  logic          last_elem;
  logic [CW-1:0] col_next;
  logic [RW-1:0] row_next;
  e_t            w_e;
  logic [OW-1:0] o_word;

  assign i_fire    = bus.i_valid && i_ready_q;
  assign w_fire    = bus.w_valid && w_ready_q;
  assign o_fire    = o_valid_q   && bus.o_ready;
  assign w_e       = e_t'(bus.w_data);

  // Row-major walk over the N x D element grid, shared by X load and Gram pass.
  assign last_elem = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign col_next  = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  assign row_next  = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;

  // Row sums of H feed the single-cycle mean.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_sum[i] = '0;
      for (int j = 0; j < N; j++) begin
        row_sum[i] = row_sum[i] + s_t'(h_q[i][j]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    x_d     = x_q;
    h_d     = h_q;
    avg_d   = avg_q;
    out_d   = out_q;

    case (state_q)
      S_LOAD_X: begin
        if (i_fire) begin
          x_d[row_q][col_q] = e_t'(bus.i_data);
          col_d             = col_next;
          row_d             = row_next;
          if (last_elem) state_d = S_GRAM;
        end
      end

      S_GRAM: begin
        // Cycle (i,k): row i of H gains X[i][k]*X[j][k] for every j at once.
        for (int j = 0; j < N; j++) begin
          h_d[row_q][j] = h_q[row_q][j]
                        + h_t'(p_t'(x_q[row_q][col_q]) * p_t'(x_q[j][col_q]));
        end
        col_d = col_next;
        row_d = row_next;
        if (last_elem) state_d = S_AVG;
      end

      S_AVG: begin
        for (int i = 0; i < N; i++) begin
          avg_d[i] = h_t'(row_sum[i] >>> LGN);
        end
        state_d = S_LOAD_W;
      end

      S_LOAD_W: begin
        if (w_fire) begin
          // Column row_q of H is masked against each row mean; ties are kept.
          for (int i = 0; i < N; i++) begin
            out_d[i] = out_q[i]
                     + a_t'((h_q[i][row_q] >= avg_q[i]) ? h_q[i][row_q] : h_t'(0))
                     * a_t'(w_e);
          end
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (o_fire) begin
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) begin
            // Frame done: drop all accumulated state so the next frame starts clean.
            h_d     = '{default: '0};
            avg_d   = '{default: '0};
            out_d   = '{default: '0};
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD_X;
          end
        end
      end

      default: state_d = S_LOAD_X;
    endcase

    // Handshake flags are registered from the next state so each one is high
    // exactly while its own phase is current, and i_ready stays low during reset.
    i_ready_d = (state_d == S_LOAD_X);
    w_ready_d = (state_d == S_LOAD_W);
    o_valid_d = (state_d == S_OUT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD_X;
      row_q     <= '0;
      col_q     <= '0;
      i_ready_q <= 1'b0;
      w_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      // NOTE: the arrays are reset along with the control so an abort leaves
      // no stale partial Gram or accumulator values behind for the next frame.
      x_q       <= '{default: '0};
      h_q       <= '{default: '0};
      avg_q     <= '{default: '0};
      out_q     <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed from the same pre-edge state.
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      i_ready_q <= i_ready_d;
      w_ready_q <= w_ready_d;
      o_valid_q <= o_valid_d;
      x_q       <= x_d;
      h_q       <= h_d;
      avg_q     <= avg_d;
      out_q     <= out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The size cast keeps the accumulator's signedness, so this sign-extends in
  // the signed build and zero-extends otherwise.
  assign o_word      = OW'(out_q[row_q]);

  assign bus.i_ready = i_ready_q;
  assign bus.w_ready = w_ready_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_valid_q ? o_word : '0;

endmodule

// File: tb/tb_dcs_sparse_attn.sv
// -----------------------------------------------------------------------------
// tb_dcs_sparse_attn
// Drives two core instances (default N=8,D=16,DW=8,OW=32 and a small
// N=4,D=2,DW=4,OW=16) through one shared stimulus front end selected by 'sel'.
// Expected outputs come from a plain integer model of the mathematical
// definition: H = X*X^T, keep H[i][j] when it is not below floor(row mean),
// out[i] = sum of kept H[i][j]*w[j].
// -----------------------------------------------------------------------------
module tb_dcs_sparse_attn;

  localparam int NA = 8, DA = 16, DWA = 8, OWA = 32;
  localparam int NB = 4, DB = 2,  DWB = 4, OWB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dcs_sparse_attn_if #(.DW(DWA), .OW(OWA)) bus_a ();
  dcs_sparse_attn_if #(.DW(DWB), .OW(OWB)) bus_b ();

  dcs_sparse_attn #(.N(NA), .D(DA), .DW(DWA), .OW(OWA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dcs_sparse_attn #(.N(NB), .D(DB), .DW(DWB), .OW(OWB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Shared stimulus, steered to one instance at a time.
  logic       sel   = 1'b0;
  logic       iv    = 1'b0;
  logic       wv    = 1'b0;
  logic       ordy  = 1'b0;
  logic [7:0] idata = 8'h0;
  logic [7:0] wdata = 8'h0;

  assign bus_a.i_valid = iv & ~sel;
  assign bus_a.i_data  = idata;
  assign bus_a.w_valid = wv & ~sel;
  assign bus_a.w_data  = wdata;
  assign bus_a.o_ready = ordy & ~sel;
  assign bus_b.i_valid = iv & sel;
  assign bus_b.i_data  = idata[3:0];
  assign bus_b.w_valid = wv & sel;
  assign bus_b.w_data  = wdata[3:0];
  assign bus_b.o_ready = ordy & sel;

  logic        i_rdy, w_rdy, o_vld;
  logic [31:0] o_dat;
  assign i_rdy = sel ? bus_b.i_ready : bus_a.i_ready;
  assign w_rdy = sel ? bus_b.w_ready : bus_a.w_ready;
  assign o_vld = sel ? bus_b.o_valid : bus_a.o_valid;
  assign o_dat = sel ? {16'h0, bus_b.o_data} : bus_a.o_data;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         cur_n  = NA;
  int         cur_d  = DA;
  int         cur_dw = DWA;
  logic [7:0] xb [8][16];
  logic [7:0] wb [8];
  longint     exp_o [8];
  int         wcnt;
  longint     c_lastx, c_lastw, c_wrdy, c_ov;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic longint val(input logic [7:0] b);
    longint v;
    v = longint'(b) & ((longint'(1) << cur_dw) - 1);
`ifdef DCSF_SIGNED_EN
    if (v >= (longint'(1) << (cur_dw - 1))) v = v - (longint'(1) << cur_dw);
`endif
    return v;
  endfunction

  task automatic build_expect();
    longint h [8][8];
    longint s;
    for (int i = 0; i < cur_n; i++)
      for (int j = 0; j < cur_n; j++) begin
        h[i][j] = 0;
        for (int k = 0; k < cur_d; k++) h[i][j] += val(xb[i][k]) * val(xb[j][k]);
      end
    for (int i = 0; i < cur_n; i++) begin
      s = 0;
      for (int j = 0; j < cur_n; j++) s += h[i][j];
      exp_o[i] = 0;
      // h >= floor(s/n)  <=>  s < n*(h+1) for integer h
      for (int j = 0; j < cur_n; j++)
        if (s < longint'(cur_n) * (h[i][j] + 1)) exp_o[i] += h[i][j] * val(wb[j]);
    end
  endtask

  task automatic use_a();
    sel = 1'b0; cur_n = NA; cur_d = DA; cur_dw = DWA;
  endtask

  task automatic use_b();
    sel = 1'b1; cur_n = NB; cur_d = DB; cur_dw = DWB;
  endtask

  // ---------------------------------------------------------------------------
  // Stream drivers and collector (decisions made at negedge, consumed at posedge)
  // ---------------------------------------------------------------------------
  task automatic drive_x(input bit gaps);
    int e = 0;
    int t = 0;
    while (e < cur_n * cur_d && t < 5000) begin
      @(negedge clk);
      t++;
      iv    = !(gaps && ($urandom_range(0, 3) == 0));
      idata = iv ? xb[e / cur_d][e % cur_d] : 8'($urandom);
      if (iv && i_rdy) begin
        e++;
        c_lastx = cyc;
      end
    end
    @(negedge clk);
    iv = 1'b0;
    checks++;
    if (e != cur_n * cur_d) begin
      errors++;
      $display("FAIL x_stream: accepted %0d elements, required %0d", e, cur_n * cur_d);
    end
  endtask

  task automatic drive_w(input bit gaps);
    int t = 0;
    while (wcnt < cur_n && t < 5000) begin
      @(negedge clk);
      t++;
      wv    = !(gaps && ($urandom_range(0, 3) == 0));
      wdata = wv ? wb[wcnt] : 8'($urandom);
      if (wv && w_rdy) begin
        wcnt++;
        c_lastw = cyc;
      end
    end
    @(negedge clk);
    wv = 1'b0;
    checks++;
    if (wcnt != cur_n) begin
      errors++;
      $display("FAIL w_stream: accepted %0d weights, required %0d", wcnt, cur_n);
    end
  endtask

  task automatic collect(input bit gaps, input string tag);
    int          words = 0;
    int          t     = 0;
    int          early = 0;
    bit          hold  = 1'b0;
    logic [31:0] prev  = '0;
    logic [31:0] ev;
    c_wrdy = -1;
    c_ov   = -1;
    while (words < cur_n && t < 8000) begin
      @(negedge clk);
      t++;
      if (w_rdy && c_wrdy < 0) c_wrdy = cyc;
      if (o_vld && c_ov < 0)   c_ov   = cyc;
      if (o_vld && wcnt < cur_n) early++;
      if (hold) begin
        checks++;
        if (!o_vld || o_dat !== prev) begin
          errors++;
          $display("FAIL %s hold[%0d]: got valid=%0b data=%0h, required valid=1 data=%0h",
                   tag, words, o_vld, o_dat, prev);
        end
      end
      ordy = !(gaps && ($urandom_range(0, 2) == 0));
      hold = 1'b0;
      if (o_vld) begin
        if (ordy) begin
          ev = 32'(exp_o[words]);
          if (sel) ev = {16'h0, ev[15:0]};
          checks++;
          if (o_dat !== ev) begin
            errors++;
            $display("FAIL %s out[%0d]: got %0h, required %0h", tag, words, o_dat, ev);
          end
          words++;
        end else begin
          hold = 1'b1;
          prev = o_dat;
        end
      end
    end
    checks++;
    if (words != cur_n) begin
      errors++;
      $display("FAIL %s word_count: got %0d, required %0d", tag, words, cur_n);
    end
    @(negedge clk);
    ordy = 1'b0;
    checks++;
    if (o_vld !== 1'b0 || i_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_end: got o_valid=%0b i_ready=%0b, required 0/1", tag, o_vld, i_rdy);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL %s early_valid: o_valid high %0d cycles before weights done, required 0", tag, early);
    end
  endtask

  task automatic run_frame(input bit gaps, input bit lat, input string tag);
    build_expect();
    wcnt    = 0;
    c_lastx = -1;
    c_lastw = -1;
    fork
      drive_x(gaps);
      drive_w(gaps);
      collect(gaps, tag);
    join
    if (lat) begin
      checks++;
      if (c_wrdy - c_lastx != longint'(cur_n * cur_d + 2)) begin
        errors++;
        $display("FAIL %s x_to_wready: got %0d cycles, required %0d", tag, c_wrdy - c_lastx, cur_n * cur_d + 2);
      end
      checks++;
      if (c_ov - c_lastw != 1) begin
        errors++;
        $display("FAIL %s w_to_ovalid: got %0d cycles, required 1", tag, c_ov - c_lastw);
      end
    end
  endtask

  task automatic fill_const(input logic [7:0] xv, input logic [7:0] wval);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) xb[i][k] = xv;
      wb[i] = wval;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) xb[i][k] = 8'($urandom);
      wb[i] = 8'($urandom);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic check_idle(input string tag);
    checks++;
    if (i_rdy !== 1'b0 || w_rdy !== 1'b0 || o_vld !== 1'b0 || o_dat !== 32'h0) begin
      errors++;
      $display("FAIL %s: got i_ready=%0b w_ready=%0b o_valid=%0b o_data=%0h, required all 0",
               tag, i_rdy, w_rdy, o_vld, o_dat);
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    @(negedge clk);
    use_a();
    #1 check_idle("reset_a");
    use_b();
    #1 check_idle("reset_b");
    use_a();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (i_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: i_ready=%0b before first clock, required 0", i_rdy);
    end
    @(negedge clk);
    checks++;
    if (i_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_clk: i_ready=%0b, required 1", i_rdy);
    end
  endtask

  task automatic test_ones();
    use_a();
    fill_const(8'd1, 8'd1);
    run_frame(1'b0, 1'b1, "ones");
  endtask

  task automatic test_ramp(input bit gaps);
    use_a();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) xb[i][k] = 8'(i + 1);
      wb[i] = 8'd1;
    end
    run_frame(gaps, !gaps, gaps ? "ramp_gaps" : "ramp");
  endtask

  task automatic test_all_ff();
    use_a();
    fill_const(8'hFF, 8'hFF);
    run_frame(1'b0, 1'b0, "all_ff");
  endtask

  task automatic test_random();
    use_a();
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    use_a();
    fill_random();
    drive_x(1'b0);
    wv    = 1'b1;               // early weights must be held off
    wdata = 8'h5A;
    repeat (40) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("mid_reset");
    wv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (o_vld) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: o_valid high %0d cycles, required 0", bad);
    end
    fill_const(8'd1, 8'd1);
    run_frame(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    use_b();
    fill_const(8'd15, 8'd15);
    run_frame(1'b0, 1'b1, "small_f1");
    run_frame(1'b0, 1'b0, "small_f2");
    fill_random();
    run_frame(1'b1, 1'b0, "small_rand");
    use_a();
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_all_ff();
    test_random();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
